// File: rtl/snow64_instr_cache_param.sv
// snow64_instr_cache_param
//   Direct-mapped instruction cache between the fetch stage and the memory
//   arbiter. Address split (LSB->MSB): dont_care | line_index | arr_index | tag,
//   all widths derived from the parameters.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   in_req_read__req/addr       fetch request and byte address
//   in_flush                    invalidate-all request
//   out_req_read__busy          high whenever the FSM is not idle
//   out_req_read__valid/instr   one-cycle pulse with the fetched word
//   out_mem_access__req/addr    line fill request, line-aligned address
//   in_mem_access__valid/data   fill response
//   out_hit_count/out_miss_count (only with SNOW64_ICACHE_PERF_COUNTERS_EN)
//
// Optional build macro: SNOW64_ICACHE_PERF_COUNTERS_EN adds hit/miss counters.
module snow64_instr_cache_param #(
  parameter int WIDTH__CPU_ADDR     = 64,
  parameter int WIDTH__INSTR        = 32,
  parameter int WIDTH__LINE_DATA    = 256,
  parameter int ARR_SIZE__NUM_LINES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_req_read__req,
  input  logic [WIDTH__CPU_ADDR-1:0]  in_req_read__addr,
  input  logic                        in_flush,
  output logic                        out_req_read__busy,
  output logic                        out_req_read__valid,
  output logic [WIDTH__INSTR-1:0]     out_req_read__instr,
  output logic                        out_mem_access__req,
  output logic [WIDTH__CPU_ADDR-1:0]  out_mem_access__addr,
  input  logic                        in_mem_access__valid,
  input  logic [WIDTH__LINE_DATA-1:0] in_mem_access__data
`ifdef SNOW64_ICACHE_PERF_COUNTERS_EN
  ,
  output logic [31:0]                 out_hit_count,
  output logic [31:0]                 out_miss_count
`endif
);

  localparam int W_DC   = $clog2(WIDTH__INSTR / 8);
  localparam int W_LI   = $clog2(WIDTH__LINE_DATA / WIDTH__INSTR);
  localparam int W_AI   = $clog2(ARR_SIZE__NUM_LINES);
  localparam int W_OFS  = W_DC + W_LI;
  localparam int W_TAG  = WIDTH__CPU_ADDR - W_OFS - W_AI;
  localparam int W_LI_S = (W_LI > 0) ? W_LI : 1;  // keeps single-word lines legal

  localparam logic [WIDTH__CPU_ADDR-1:0] ALIGN_MASK = {WIDTH__CPU_ADDR{1'b1}} << W_OFS;
  localparam logic [W_AI-1:0]            LAST_LINE  = W_AI'(ARR_SIZE__NUM_LINES - 1);

  typedef logic [WIDTH__CPU_ADDR-1:0] addr_t;

  function automatic logic [W_LI_S-1:0] f_li(input addr_t a);
    return (W_LI == 0) ? '0 : W_LI_S'(a >> W_DC);
  endfunction

  function automatic logic [W_AI-1:0] f_ai(input addr_t a);
    return W_AI'(a >> W_OFS);
  endfunction

  function automatic logic [W_TAG-1:0] f_tag(input addr_t a);
    return W_TAG'(a >> (W_OFS + W_AI));
  endfunction

  function automatic logic [WIDTH__INSTR-1:0] f_word(input logic [WIDTH__LINE_DATA-1:0] line,
                                                      input logic [W_LI_S-1:0] li);
    return WIDTH__INSTR'(line >> (li * WIDTH__INSTR));
  endfunction

  typedef enum logic [1:0] {StIdle, StWaitForMem, StFlush} state_t;

  state_t                      state, state_nxt;
  logic [ARR_SIZE__NUM_LINES-1:0] line_vld;
  logic [W_TAG-1:0]            tag_arr  [ARR_SIZE__NUM_LINES];
  logic [WIDTH__LINE_DATA-1:0] data_arr [ARR_SIZE__NUM_LINES];
  addr_t                       miss_addr;
  logic                        flush_pending;
  logic [W_AI-1:0]             flush_cnt;

  logic [W_AI-1:0] rd_ai;
  logic            req_hit;
  logic            acc_req;
  logic            fill_done;

  assign rd_ai     = f_ai(in_req_read__addr);
  assign req_hit   = line_vld[rd_ai] && (tag_arr[rd_ai] == f_tag(in_req_read__addr));
  // flush wins over a same-cycle request in idle
  assign acc_req   = (state == StIdle) && !in_flush && in_req_read__req;
  assign fill_done = (state == StWaitForMem) && in_mem_access__valid;

  assign out_req_read__busy = (state != StIdle);

  always_comb begin
    state_nxt = state;
    case (state)
      StIdle:       if (in_flush)             state_nxt = StFlush;
                    else if (acc_req && !req_hit) state_nxt = StWaitForMem;
      // a flush arriving with the fill data is treated as already pending
      StWaitForMem: if (in_mem_access__valid) state_nxt = (flush_pending || in_flush) ? StFlush : StIdle;
      StFlush:      if (flush_cnt == LAST_LINE) state_nxt = StIdle;
      default:      state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= StIdle;
      line_vld             <= '0;
      miss_addr            <= '0;
      flush_pending        <= 1'b0;
      flush_cnt            <= '0;
      out_req_read__valid  <= 1'b0;
      out_req_read__instr  <= '0;
      out_mem_access__req  <= 1'b0;
      out_mem_access__addr <= '0;
    end else begin
      state               <= state_nxt;
      out_req_read__valid <= 1'b0;
      case (state)
        StIdle: begin
          if (in_flush) begin
            flush_cnt <= '0;
          end else if (acc_req) begin
            if (req_hit) begin
              out_req_read__valid <= 1'b1;
              out_req_read__instr <= f_word(data_arr[rd_ai], f_li(in_req_read__addr));
            end else begin
              miss_addr            <= in_req_read__addr;
              out_mem_access__req  <= 1'b1;
              out_mem_access__addr <= in_req_read__addr & ALIGN_MASK;
            end
          end
        end
        StWaitForMem: begin
          if (in_flush) flush_pending <= 1'b1;
          if (in_mem_access__valid) begin
            line_vld[f_ai(miss_addr)] <= 1'b1;
            out_mem_access__req       <= 1'b0;
            out_req_read__valid       <= 1'b1;
            out_req_read__instr       <= f_word(in_mem_access__data, f_li(miss_addr));
            flush_cnt                 <= '0;
          end
        end
        StFlush: begin
          line_vld[flush_cnt] <= 1'b0;
          flush_cnt           <= flush_cnt + W_AI'(1);
          if (flush_cnt == LAST_LINE) flush_pending <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // tag/data need no reset: they are only read behind a set valid bit
  always_ff @(posedge clk) begin
    if (fill_done) begin
      tag_arr[f_ai(miss_addr)]  <= f_tag(miss_addr);
      data_arr[f_ai(miss_addr)] <= in_mem_access__data;
    end
  end

`ifdef SNOW64_ICACHE_PERF_COUNTERS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hit_count  <= '0;
      out_miss_count <= '0;
    end else if (acc_req) begin
      if (req_hit) out_hit_count  <= out_hit_count + 32'd1;
      else         out_miss_count <= out_miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_snow64_instr_cache_param.sv
module tb_snow64_instr_cache_param;
  localparam int AW = 64, IW = 32, LW = 256, NL = 64;
  localparam int LB = LW / 8;  // bytes per line
  localparam int IB = IW / 8;  // bytes per instruction

  logic          clk = 0;
  logic          rst_n = 0;
  logic          req = 0;
  logic [AW-1:0] addr = '0;
  logic          flush = 0;
  logic          busy, valid;
  logic [IW-1:0] instr;
  logic          mreq;
  logic [AW-1:0] maddr;
  logic          mvalid = 0;
  logic [LW-1:0] mdata = '0;
`ifdef SNOW64_ICACHE_PERF_COUNTERS_EN
  logic [31:0]   hit_cnt, miss_cnt;
`endif

  snow64_instr_cache_param #(
    .WIDTH__CPU_ADDR(AW), .WIDTH__INSTR(IW), .WIDTH__LINE_DATA(LW), .ARR_SIZE__NUM_LINES(NL)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_read__req(req), .in_req_read__addr(addr), .in_flush(flush),
    .out_req_read__busy(busy), .out_req_read__valid(valid), .out_req_read__instr(instr),
    .out_mem_access__req(mreq), .out_mem_access__addr(maddr),
    .in_mem_access__valid(mvalid), .in_mem_access__data(mdata)
`ifdef SNOW64_ICACHE_PERF_COUNTERS_EN
    , .out_hit_count(hit_cnt), .out_miss_count(miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          m_vld  [NL];
  logic [AW-1:0] m_tag  [NL];
  logic [LW-1:0] m_line [NL];
  logic          m_fill = 0, m_flush_pend = 0;
  int            m_flush_left = 0;
  logic [AW-1:0] m_miss_addr = '0;
  logic          e_valid = 0, e_mreq = 0;
  logic [IW-1:0] e_instr = '0;
  logic [AW-1:0] e_maddr = '0;
  logic [31:0]   m_hits = 0, m_misses = 0;

  function automatic int a_ai(input logic [AW-1:0] a);  return int'((a / LB) % NL);      endfunction
  function automatic logic [AW-1:0] a_tag(input logic [AW-1:0] a); return a / (LB * NL); endfunction
  function automatic int a_li(input logic [AW-1:0] a);  return int'((a % LB) / IB);      endfunction
  function automatic logic [IW-1:0] a_word(input logic [LW-1:0] l, input int li);
    return l[li*IW +: IW];
  endfunction

  task automatic m_start_flush();
    for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
    m_flush_left = NL;
    m_flush_pend = 1'b0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) m_vld[i] = 1'b0;
      m_fill = 0; m_flush_pend = 0; m_flush_left = 0;
      e_valid = 0; e_instr = '0; e_mreq = 0; e_maddr = '0;
      m_hits = 0; m_misses = 0;
    end else begin
      e_valid = 0;
      if (m_flush_left > 0) begin
        m_flush_left--;
      end else if (m_fill) begin
        if (mvalid) begin
          int ai;
          ai = a_ai(m_miss_addr);
          m_vld[ai] = 1'b1; m_tag[ai] = a_tag(m_miss_addr); m_line[ai] = mdata;
          e_valid = 1; e_instr = a_word(mdata, a_li(m_miss_addr));
          e_mreq = 0; m_fill = 0;
          if (m_flush_pend || flush) m_start_flush();
        end else if (flush) begin
          m_flush_pend = 1;
        end
      end else if (flush) begin
        m_start_flush();
      end else if (req) begin
        int ai;
        ai = a_ai(addr);
        if (m_vld[ai] && m_tag[ai] == a_tag(addr)) begin
          e_valid = 1; e_instr = a_word(m_line[ai], a_li(addr)); m_hits++;
        end else begin
          m_fill = 1; m_miss_addr = addr; e_mreq = 1; e_maddr = addr - (addr % LB); m_misses++;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("busy", busy, m_fill || (m_flush_left > 0));
    chk("valid", valid, e_valid);
    chk("mem_req", mreq, e_mreq);
    if (e_mreq)  chk("mem_addr", maddr, e_maddr);
    if (e_valid) chk("instr", instr, e_instr);
`ifdef SNOW64_ICACHE_PERF_COUNTERS_EN
    chk("hit_count", hit_cnt, m_hits);
    chk("miss_count", miss_cnt, m_misses);
`endif
  end

  // ---------------- stimulus ----------------
  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int w = 0; w < LW / 32; w++) l[w*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic issue(input logic [AW-1:0] a);
    req = 1; addr = a;
    @(negedge clk);
    req = 0;
  endtask

  task automatic fill(input logic [LW-1:0] l);
    mvalid = 1; mdata = l;
    @(negedge clk);
    mvalid = 0;
  endtask

  task automatic count_busy(input string nm, input int start, input int exp);
    int n;
    n = start;
    while (busy && n < 200) begin n++; @(negedge clk); end
    chk(nm, n, exp);
  endtask

  logic [LW-1:0] line;
  int            resp_cnt;

  initial begin
    // reset state
    @(negedge clk);
    chk("rst_busy", busy, 0); chk("rst_valid", valid, 0); chk("rst_mreq", mreq, 0);
    chk("rst_maddr", maddr, 0); chk("rst_instr", instr, 0);
    rst_n = 1;
    @(negedge clk);

    // cold miss
    issue(64'h1004);
    chk("cold_busy", busy, 1); chk("cold_mreq", mreq, 1); chk("cold_maddr", maddr, 64'h1000);
    line = rand_line();
    line[31:0] = 32'h11111111; line[63:32] = 32'hDEADBEEF; line[255:224] = 32'h77777777;
    fill(line);
    chk("cold_valid", valid, 1); chk("cold_instr", instr, 32'hDEADBEEF); chk("cold_busy_done", busy, 0);

    // back-to-back hits, then misaligned
    req = 1; addr = 64'h1000;
    @(negedge clk); addr = 64'h101C;
    chk("hit0_valid", valid, 1); chk("hit0_instr", instr, 32'h11111111); chk("hit0_mreq", mreq, 0);
    @(negedge clk); addr = 64'h1006;
    chk("hit7_valid", valid, 1); chk("hit7_instr", instr, 32'h77777777); chk("hit7_mreq", mreq, 0);
    @(negedge clk); req = 0;
    chk("mis_valid", valid, 1); chk("mis_instr", instr, 32'hDEADBEEF); chk("mis_mreq", mreq, 0);
    @(negedge clk);
    chk("pulse_once", valid, 0);

    // conflict eviction
    issue(64'h3000);
    chk("evict_mreq", mreq, 1); chk("evict_maddr", maddr, 64'h3000);
    fill(rand_line());
    issue(64'h1000);
    chk("evict_back_mreq", mreq, 1); chk("evict_back_maddr", maddr, 64'h1000);
    fill(line);

    // flush in idle
    flush = 1; @(negedge clk); flush = 0;
    count_busy("flush_idle_len", 0, 64);
    issue(64'h1000);
    chk("post_flush_miss", mreq, 1);
    fill(line);

    // flush during fill
    issue(64'h2000);
    chk("wflush_mreq", mreq, 1);
    flush = 1; @(negedge clk); flush = 0;
    line[31:0] = 32'hCAFEF00D;
    fill(line);
    chk("wflush_valid", valid, 1); chk("wflush_instr", instr, 32'hCAFEF00D);
    count_busy("wflush_len", 0, 64);

    // reset mid-miss
    issue(64'h1000);
    chk("rmid_mreq", mreq, 1);
    #2 rst_n = 0;
    #1 chk("rmid_mreq0", mreq, 0); chk("rmid_valid0", valid, 0); chk("rmid_busy0", busy, 0);
    @(negedge clk); rst_n = 1;
    @(negedge clk);

    // 1 miss, 3 hits, flush, 1 miss
    issue(64'h1000);
    chk("rrel_miss", mreq, 1);
    fill(line);
    req = 1; addr = 64'h1000; @(negedge clk);
    addr = 64'h1004; @(negedge clk);
    addr = 64'h1008; @(negedge clk);
    req = 0;
    flush = 1; @(negedge clk); flush = 0;
    count_busy("perf_flush_len", 0, 64);
    issue(64'h1000);
    chk("perf_miss2", mreq, 1);
    fill(line);
`ifdef SNOW64_ICACHE_PERF_COUNTERS_EN
    chk("perf_hits_lit", hit_cnt, 3);
    chk("perf_miss_lit", miss_cnt, 2);
`endif

    // randomized traffic with a randomly delayed memory responder
    resp_cnt = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      mvalid = 0;
      if (mreq) begin
        if (resp_cnt < 0) resp_cnt = $urandom_range(0, 3);
        if (resp_cnt == 0) begin mvalid = 1; mdata = rand_line(); resp_cnt = -1; end
        else resp_cnt--;
      end else if ($urandom_range(0, 9) == 0) begin
        mvalid = 1; mdata = rand_line();
      end
      flush = ($urandom_range(0, 59) == 0);
      req   = ($urandom_range(0, 9) < 7);
      addr  = ((64'($urandom_range(0, 3)) * NL + 64'($urandom_range(0, 3))) * LB)
              + 64'($urandom_range(0, LB - 1));
    end
    @(negedge clk);
    req = 0; flush = 0; mvalid = 0;
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snow64_instr_cache_param.md
Name: snow64_instr_cache_param

Overview:
- Parametrised next-generation direct-mapped instruction cache between the Snow64 fetch stage and the memory arbiter.
- Tag, array index, line index and byte-offset widths are derived from parameters rather than fixed defines.
- Adds over the prior generation: explicit busy handshake, whole-cache flush sweep, deferred flush during a fill, and optional hit/miss counters.

Parameters:
- WIDTH__CPU_ADDR, 64: CPU byte address width.
- WIDTH__INSTR, 32: instruction width in bits; power of two, at least 8.
- WIDTH__LINE_DATA, 256: line width in bits; power-of-two multiple of WIDTH__INSTR.
- ARR_SIZE__NUM_LINES, 64: number of lines; power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_req_read__req  in  1  fetch request
- in_req_read__addr  in  WIDTH__CPU_ADDR  fetch byte address
- in_flush  in  1  invalidate-all request
- out_req_read__busy  out  1  cache cannot accept a request this cycle
- out_req_read__valid  out  1  one-cycle pulse; instr is valid
- out_req_read__instr  out  WIDTH__INSTR  fetched instruction
- out_mem_access__req  out  1  line fill request
- out_mem_access__addr  out  WIDTH__CPU_ADDR  line-aligned fill address
- in_mem_access__valid  in  1  fill data valid
- in_mem_access__data  in  WIDTH__LINE_DATA  fill line data

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low.
- Address split, LSB to MSB:
  - dont_care: log2(WIDTH__INSTR/8) bits.
  - line_index: log2(WIDTH__LINE_DATA/WIDTH__INSTR) bits.
  - arr_index: log2(ARR_SIZE__NUM_LINES) bits.
  - tag: all remaining bits.
- dont_care bits are ignored, so misaligned addresses read the containing word.
- Storage per line: valid bit, tag, data.
- Reset state: all valid bits 0; state StIdle; valid, mem req, mem addr and instr outputs all 0; busy 0.
- Busy rule: out_req_read__busy = (state != StIdle), combinational. A request is accepted when req=1 and busy=0.
- StIdle, flush priority: if in_flush=1, ignore req, clear the flush counter, go to StFlush.
- StIdle, accepted hit (line valid and tag match): next cycle valid=1 and instr = word[line_index]. Hit latency is 1 cycle. Back-to-back hits are allowed every cycle.
- StIdle, accepted miss:
  - Latch the address.
  - Next cycle: state StWaitForMem, mem req=1, mem addr = address with line_index and dont_care zeroed.
- StWaitForMem:
  - Hold mem req and mem addr steady until in_mem_access__valid=1.
  - On valid: write data, tag and valid=1 into arr_index, overwriting any previous tag.
  - Next cycle: mem req=0, valid=1 with the requested word from the fill data, state StIdle (or StFlush if a flush is pending).
- Flush during StWaitForMem: set flush_pending. The fill still completes and the instruction is still returned.
- StFlush:
  - One valid bit cleared per cycle, counter 0 to ARR_SIZE__NUM_LINES-1, so the sweep takes exactly ARR_SIZE__NUM_LINES cycles.
  - Then StIdle, flush_pending cleared.
  - in_flush asserted during StFlush is ignored.
- Ignored memory input: in_mem_access__valid outside StWaitForMem is ignored.
- Reset mid-operation: all state above returns to reset values immediately and the outstanding fill is abandoned. The arbiter must also be reset.
- Output pulse: out_req_read__valid is high for exactly one cycle per accepted request.

Optional Feature:
- Macro: SNOW64_ICACHE_PERF_COUNTERS_EN.
- When defined, adds two ports:
  - out_hit_count  out  32: increments on each accepted hit.
  - out_miss_count  out  32: increments on each accepted miss.
- Both counters reset to 0, wrap modulo 2^32, and are not cleared by flush.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, req addr 0x1004.
  - Required: busy=1 the next cycle; mem req=1, mem addr=0x1000.
  - Drive mem valid with data word1=0xDEADBEEF. Required: next cycle valid=1, instr=0xDEADBEEF, busy=0.
- Hit:
  - After the cold miss, req 0x1000 then 0x101C on consecutive cycles. Required: two consecutive valid pulses, 1-cycle latency each, returning words 0 and 7 of the line; no mem req.
  - Req 0x1006 (misaligned). Required: returns word1 with 1-cycle latency, no mem req.
- Conflict eviction: with default parameters, fill 0x1000 then req 0x3000 (same arr_index, different tag).
  - Required: a miss with mem addr 0x3000.
  - Then req 0x1000. Required: a miss again.
- Flush:
  - Flush in StIdle. Required: busy=1 for exactly 64 cycles; then req 0x1000 misses.
  - Assert in_flush during StWaitForMem. Required: the fill returns its instruction, then a 64-cycle flush sweep follows.
- Reset mid-miss: drop rst_n while mem req=1.
  - Required: mem req=0 and valid=0 immediately.
  - After release, req 0x1000 misses.
- Perf counters (macro defined): 1 miss, 3 hits, flush, 1 miss.
  - Required: hit_count=3, miss_count=2.
